muldiv_unit: RTL
================

# muldiv_unit

Parametrised multi-cycle multiply/divide unit owning the architectural HI/LO registers for the MIPS core. It sits beside the execute-stage ALU: execute issues MULT/MULTU/DIV/DIVU/MADD/MADDU/MTHI/MTLO through a valid/ready handshake and stalls MFHI/MFLO until `hilo_valid` is high. Compared with a combinational HI/LO update, it adds:
- an iterative divider;
- a configurable multiply latency;
- multiply-accumulate;
- divide-by-zero and overflow definitions;
- a flush path.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `MUL_LATENCY`, 4: cycles from accept to HI/LO commit for MULT/MULTU/MADD/MADDU; legal range 1..8.
- `clk` in 1: clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_valid` in 1: operation request.
- `start_ready` out 1: high only in IDLE; an operation is accepted when valid and ready are both high and `flush` is low.
- `op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MTHI, 7 MTLO.
- `rs_val` in `WIDTH`: multiplicand, dividend, or MTHI/MTLO source.
- `rt_val` in `WIDTH`: multiplier or divisor.
- `flush` in 1: abort the in-flight operation; HI/LO are not written.
- `busy` out 1: an operation is in flight (any state other than IDLE).
- `done` out 1: one-cycle pulse in the cycle after HI/LO commit.
- `hilo_valid` out 1: equals `~busy`.
- `hi` out `WIDTH`: HI register.
- `lo` out `WIDTH`: LO register.

## Operation
**Capture and request handling**
- Operands and `op` are captured at accept; later input changes are ignored.
- Requests while busy are ignored; the requester must hold `start_valid`.

**State machine**: IDLE, MUL, DIV, FIX.
- IDLE → MUL on accept of op 0/1/4/5.
- IDLE → DIV on accept of op 2/3 with nonzero divisor.
- MTHI/MTLO: written at the accept edge; the state stays IDLE.
- Divide-by-zero at accept: the result is written at the accept edge; the state stays IDLE.
- MUL: a down-counter is loaded with `MUL_LATENCY-1`. When it reaches 0, HI/LO are committed and the state returns to IDLE.
- DIV: one restoring step per cycle on magnitudes for `WIDTH` cycles, then → FIX.
- FIX: sign correction, commit, → IDLE.

**Arithmetic**
- MULT/MADD: signed `2*WIDTH` product.
- MULTU/MADDU: unsigned `2*WIDTH` product.
- MADD/MADDU: {HI,LO} ← {HI,LO} + product, modulo 2^(2*WIDTH).
- The accumulate uses HI/LO as they are at commit; HI/LO cannot change while busy.
- DIV quotient truncates toward zero; the remainder takes the sign of the dividend. LO = quotient, HI = remainder.
- Divide by zero (DIV and DIVU): HI = `rs_val`, LO = all ones.
- DIV of most-negative by -1: LO = most-negative, HI = 0.

**Flush and reset**
- `flush` while busy: return to IDLE next edge; HI/LO unchanged; no `done`.
- `flush` in IDLE with `start_valid`: the request is dropped.
- `flush` in the same cycle as a commit: flush wins and nothing is written.
- Reset at any time:
  - state IDLE, counters cleared;
  - `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0;
  - `start_ready` = 1, `hilo_valid` = 1.
- A reset mid-operation discards the operation.

## Timing
Let accept be edge E0.
- MTHI/MTLO: the new value is visible after E0; `done` is high in the cycle after E0; `busy` never rises.
- Multiply ops:
  - `busy` is high after E0 through edge E(`MUL_LATENCY`);
  - HI/LO are new after E(`MUL_LATENCY`);
  - `done` is high the following cycle;
  - the next accept is possible at E(`MUL_LATENCY`+1).
- Divide ops:
  - `WIDTH` iteration cycles plus 1 FIX cycle;
  - HI/LO are new after E(`WIDTH`+1), which is E33 at default width;
  - `done` is high the following cycle.
- Divide-by-zero: written at E0, `done` the next cycle, `busy` never rises.
- `done` and `start_ready` can both be high in the same cycle, which allows back-to-back issue.

## Structure
- Package `muldiv_pkg` holds:
  - the `op` enum (`muldiv_op_t`);
  - the state enum (`muldiv_state_t`);
  - the `MUL_LATENCY` legal-range constants.
- Sub-module `div_iter`: the restoring divider core. It takes `WIDTH`, unsigned magnitudes, and `start`/`step` inputs, and produces quotient and remainder magnitudes.
- Sign handling, the divide-by-zero and overflow cases, and the FIX stage stay in `muldiv_unit`.
- The multiply product is computed at accept and held in a `2*WIDTH` register while the latency counter runs.

## Test plan
- MULT `rs_val`=0xFFFFFFFF, `rt_val`=2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE after 4 cycles, `done` on cycle 5. MULTU with the same operands → HI=1, LO=0xFFFFFFFE.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 33 cycles. DIVU 7/2 → LO=3, HI=1.
- DIV 5/0 → HI=5, LO=0xFFFFFFFF, `done` the next cycle, `busy` stays 0. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTLO 0xFFFFFFFF, MTHI 0, then MADDU 1×1 → HI=1, LO=0. MADD (-1)×1 from HI=0/LO=0 → HI=LO=0xFFFFFFFF.
- DIV started, `flush` on cycle 10 → HI/LO unchanged, no `done`, `start_ready`=1 the next cycle. A MULT presented on cycle 5 of that DIV is ignored.
- `rst_n` low mid-MULT → `hi`=`lo`=0, `busy`=0 immediately. After release, back-to-back MULT issued in the `done` cycle is accepted.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned OP_W            = 3;
    localparam int unsigned MUL_LATENCY_MIN = 1;
    localparam int unsigned MUL_LATENCY_MAX = 8;

    typedef enum logic [OP_W-1:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MADDU = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } muldiv_state_t;

    // Accumulating multiplies add the product onto the existing HI/LO pair.
    function automatic logic is_acc_op(input muldiv_op_t op);
        return (op == OP_MADD) || (op == OP_MADDU);
    endfunction

    // Signed variants treat operands as two's complement.
    function automatic logic is_signed_op(input muldiv_op_t op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between execute stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_valid;
    logic             start_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             busy;
    logic             done;
    logic             hilo_valid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start_valid, op, rs_val, rt_val, flush,
        input  start_ready, busy, done, hilo_valid, hi, lo
    );

    modport slave (
        input  start_valid, op, rs_val, rt_val, flush,
        output start_ready, busy, done, hilo_valid, hi, lo
    );
endinterface

// File: rtl/muldiv_unit_div_iter.sv
// Restoring divider core on unsigned magnitudes: one quotient bit per step.
module div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    // Shift next dividend bit into the partial remainder and try a subtract.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        trial = {rem_q, quo_q[WIDTH-1]};
        diff  = trial - {1'b0, dvs_q};
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            if (!diff[WIDTH]) begin
                rem_d = diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Divider working registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO architectural registers.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MUL_LATENCY = 4
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);

    localparam int unsigned W2      = 2 * WIDTH;
    localparam int unsigned CNT_W   = ($clog2(WIDTH) > 3) ? $clog2(WIDTH) : 3;
    // Out-of-range latencies saturate to the supported window.
    localparam int unsigned MUL_LAT = (MUL_LATENCY < MUL_LATENCY_MIN) ? MUL_LATENCY_MIN :
                                      (MUL_LATENCY > MUL_LATENCY_MAX) ? MUL_LATENCY_MAX :
                                      MUL_LATENCY;

    muldiv_state_t    state_q, state_d;
    muldiv_op_t       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    prod_q, prod_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    muldiv_op_t       op_in;
    logic             accept;
    logic             sgn;
    logic [W2-1:0]    a_ext;
    logic [W2-1:0]    b_ext;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;
    logic             div_start;
    logic             div_step;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;

    assign op_in  = muldiv_op_t'(bus.op);
    assign accept = (state_q == ST_IDLE) && bus.start_valid && !bus.flush;
    assign sgn    = is_signed_op(op_in);

    // Operand conditioning: sign/zero extension for multiply, magnitudes for divide.
    always_comb begin
        a_ext  = sgn ? {{WIDTH{bus.rs_val[WIDTH-1]}}, bus.rs_val} : {{WIDTH{1'b0}}, bus.rs_val};
        b_ext  = sgn ? {{WIDTH{bus.rt_val[WIDTH-1]}}, bus.rt_val} : {{WIDTH{1'b0}}, bus.rt_val};
        rs_mag = (sgn && bus.rs_val[WIDTH-1]) ? (~bus.rs_val) + WIDTH'(1) : bus.rs_val;
        rt_mag = (sgn && bus.rt_val[WIDTH-1]) ? (~bus.rt_val) + WIDTH'(1) : bus.rt_val;
    end

    div_iter #(
        .WIDTH (WIDTH)
    ) u_div_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .step      (div_step),
        .dividend  (rs_mag),
        .divisor   (rt_mag),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        div_start = 1'b0;
        div_step  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = op_in;
                    case (op_in)
                        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU: begin
                            prod_d  = a_ext * b_ext;
                            cnt_d   = CNT_W'(MUL_LAT - 1);
                            state_d = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (bus.rt_val == '0) begin
                                // Divide by zero resolves immediately without a busy phase.
                                hi_d   = bus.rs_val;
                                lo_d   = {WIDTH{1'b1}};
                                done_d = 1'b1;
                            end else begin
                                div_start = 1'b1;
                                cnt_d     = CNT_W'(WIDTH - 1);
                                q_neg_d   = sgn && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                                r_neg_d   = sgn && bus.rs_val[WIDTH-1];
                                state_d   = ST_DIV;
                            end
                        end
                        OP_MTHI: begin
                            hi_d   = bus.rs_val;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = bus.rs_val;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            ST_MUL: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    if (is_acc_op(op_q)) begin
                        {hi_d, lo_d} = {hi_q, lo_q} + prod_q;
                    end else begin
                        {hi_d, lo_d} = prod_q;
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_DIV: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    div_step = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            ST_FIX: begin
                // Most-negative / -1 falls out naturally: the magnitude wraps back to itself.
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    lo_d    = q_neg_q ? (~div_quo) + WIDTH'(1) : div_quo;
                    hi_d    = r_neg_q ? (~div_rem) + WIDTH'(1) : div_rem;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= '0;
            prod_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.start_ready = ~busy_q;
    assign bus.busy        = busy_q;
    assign bus.hilo_valid  = ~busy_q;
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule
